// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution pipeline.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic int tag_width(input int index_width);
        return 32 - index_width - 2;
    endfunction

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        hit;
        logic [31:0] btb_target;
    } ifid_meta_t;

    typedef struct packed {
        ifid_meta_t  base;
        logic        is_br;
        logic        is_jmp;
        logic        is_jalr;
        logic [2:0]  funct3;
    } idex_meta_t;

    // pc is kept word-aligned only; the low two bits never reach the BTB.
    typedef struct packed {
        logic        ctl;
        logic        taken;
        logic        hit;
        logic [29:0] pc_word;
        logic [31:0] target;
        logic [31:0] pcplus4;
    } exmem_meta_t;

endpackage

// File: rtl/branch_comparator.sv
// Branch condition evaluation for the conditional branch funct3 encodings.
module branch_comparator
    import branch_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  funct3,
    output logic        cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (rs1 == rs2);
            F3_BNE:  cond = (rs1 != rs2);
            F3_BLT:  cond = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: cond = (rs1 <  rs2);
            F3_BGEU: cond = (rs1 >= rs2);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries prediction metadata IF->ID->EX->MEM, resolves control transfers in EX,
// and presents commit-side BTB/redirect signals plus saturating statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter  int INDEX_WIDTH = 6,
    localparam int TAG_WIDTH   = tag_width(INDEX_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [31:0]            IF_pc_i,
    input  logic                   IF_btb_hit_i,
    input  logic [31:0]            IF_btb_rd_target_i,
    input  logic                   IFID_stall_i,
    input  logic                   IDEX_bubble_i,
    input  logic                   flush_i,
    input  logic                   ID_is_br_i,
    input  logic                   ID_is_jmp_i,
    input  logic                   ID_is_jalr_i,
    input  logic [2:0]             ID_funct3_i,
    input  logic [31:0]            EX_rs1_i,
    input  logic [31:0]            EX_rs2_i,
    input  logic [31:0]            EX_imm_i,
    output logic [INDEX_WIDTH-1:0] EXMEM_btb_wr_index_o,
    output logic [TAG_WIDTH-1:0]   EXMEM_btb_wr_tag_o,
    output logic [31:0]            EXMEM_btb_wr_target_o,
    output logic [31:0]            EXMEM_br_target_o,
    output logic [31:0]            EXMEM_pcplus4_o,
    output logic                   EXMEM_btb_hit_o,
    output logic                   EXMEM_br_decision_o,
    output logic                   EXMEM_is_jmp_o,
    output logic [31:0]            br_count_o,
    output logic [31:0]            mispredict_count_o
);

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    ifid_meta_t  ifid_q;
    idex_meta_t  idex_q;
    exmem_meta_t exmem_q;
    logic [31:0] br_count_q;
    logic [31:0] mis_count_q;

    logic        cond;
    logic        ex_ctl;
    logic        ex_taken;
    logic        ex_hit;
    logic [31:0] ex_rs1_sum;
    logic [31:0] ex_target;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ifid_q <= '0;
        end else if (flush_i) begin
            ifid_q <= '0;
        end else if (!IFID_stall_i) begin
            ifid_q.valid      <= 1'b1;
            ifid_q.pc         <= IF_pc_i;
            ifid_q.hit        <= IF_btb_hit_i;
            ifid_q.btb_target <= IF_btb_rd_target_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idex_q <= '0;
        end else if (flush_i || IDEX_bubble_i) begin
            idex_q <= '0;
        end else begin
            idex_q.base    <= ifid_q;
            idex_q.is_br   <= ID_is_br_i;
            idex_q.is_jmp  <= ID_is_jmp_i;
            idex_q.is_jalr <= ID_is_jalr_i;
            idex_q.funct3  <= ID_funct3_i;
        end
    end

    branch_comparator u_cmp (
        .rs1    (EX_rs1_i),
        .rs2    (EX_rs2_i),
        .funct3 (idex_q.funct3),
        .cond   (cond)
    );

    always_comb begin
        ex_rs1_sum = EX_rs1_i + EX_imm_i;
        ex_target  = idex_q.is_jalr ? (ex_rs1_sum & ~32'h1) : (idex_q.base.pc + EX_imm_i);
        ex_ctl     = idex_q.base.valid & (idex_q.is_br | idex_q.is_jmp);
        ex_taken   = idex_q.is_jmp | (idex_q.is_br & cond);
        // A hit whose stored target disagrees with the resolved one counts as a miss.
        ex_hit     = ex_ctl & idex_q.base.hit &
                     (~ex_taken | (idex_q.base.btb_target == ex_target));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exmem_q <= '0;
        end else if (flush_i) begin
            exmem_q <= '0;
        end else begin
            exmem_q.ctl     <= ex_ctl;
            exmem_q.taken   <= ex_ctl & ex_taken;
            exmem_q.hit     <= ex_hit;
            exmem_q.pc_word <= idex_q.base.pc[31:2];
            exmem_q.target  <= ex_target;
            exmem_q.pcplus4 <= idex_q.base.pc + 32'd4;
        end
    end

    // Counters read the current EX/MEM entry, so a commit coinciding with its flush still counts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_count_q  <= '0;
            mis_count_q <= '0;
        end else if (exmem_q.ctl) begin
            if (br_count_q != COUNT_MAX) begin
                br_count_q <= br_count_q + 32'd1;
            end
            if ((exmem_q.hit != exmem_q.taken) && (mis_count_q != COUNT_MAX)) begin
                mis_count_q <= mis_count_q + 32'd1;
            end
        end
    end

    assign EXMEM_btb_wr_index_o  = exmem_q.pc_word[INDEX_WIDTH-1:0];
    assign EXMEM_btb_wr_tag_o    = exmem_q.pc_word[29:INDEX_WIDTH];
    assign EXMEM_btb_wr_target_o = exmem_q.target;
    assign EXMEM_br_target_o     = exmem_q.target;
    assign EXMEM_pcplus4_o       = exmem_q.pcplus4;
    assign EXMEM_btb_hit_o       = exmem_q.hit;
    assign EXMEM_br_decision_o   = exmem_q.taken;
    assign EXMEM_is_jmp_o        = exmem_q.ctl;
    assign br_count_o            = br_count_q;
    assign mispredict_count_o    = mis_count_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Carries branch-prediction metadata from Fetch through the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves every control-transfer instruction in EX: condition, target, taken decision.
- In the MEM (branch commit) stage, presents the commit-side EXMEM_* signals that drive the always-taken predictor's next-PC decoder and BTB write port.
- Keeps saturating counters of committed branches and mispredictions.

Parameters:
- INDEX_WIDTH, 6, BTB index width. TAG_WIDTH = 32-INDEX_WIDTH-2 (derived localparam, not overridable).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- IF_pc_i  in  32  Fetch-stage PC
- IF_btb_hit_i  in  1  predictor hit for IF_pc_i
- IF_btb_rd_target_i  in  32  BTB target read for IF_pc_i
- IFID_stall_i  in  1  hold IF/ID register
- IDEX_bubble_i  in  1  load ID/EX with a bubble (load-use)
- flush_i  in  1  misprediction flush (predictor flush output, fed back)
- ID_is_br_i  in  1  decoded conditional branch
- ID_is_jmp_i  in  1  decoded JAL or JALR
- ID_is_jalr_i  in  1  decoded JALR
- ID_funct3_i  in  3  branch funct3
- EX_rs1_i, EX_rs2_i  in  32 each  forwarded operands in EX
- EX_imm_i  in  32  sign-extended immediate in EX
- EXMEM_btb_wr_index_o  out  INDEX_WIDTH  committed PC[INDEX_WIDTH+1:2]
- EXMEM_btb_wr_tag_o  out  TAG_WIDTH  committed PC[31:INDEX_WIDTH+2]
- EXMEM_btb_wr_target_o  out  32  resolved target (BTB write data)
- EXMEM_br_target_o  out  32  resolved target (redirect path; same value)
- EXMEM_pcplus4_o  out  32  committed PC+4
- EXMEM_btb_hit_o  out  1  effective prediction-hit bit
- EXMEM_br_decision_o  out  1  resolved taken
- EXMEM_is_jmp_o  out  1  valid control-transfer instruction in commit stage
- br_count_o  out  32  committed control transfers
- mispredict_count_o  out  32  committed mispredictions

Behaviour:
Pipeline registers:
- IF/ID holds {valid, pc, hit, btb_target}. ID/EX adds {is_br, is_jmp, is_jalr, funct3}. EX/MEM holds resolved results.
- Per-register priority: reset > flush_i > stall/bubble > load.
- flush_i=1 at a clock edge: IF/ID, ID/EX and EX/MEM all load bubbles (valid=0). EX/MEM then holds no wrong-path result.
- IFID_stall_i=1 and flush_i=0: IF/ID holds its contents.
- IDEX_bubble_i=1 and flush_i=0: ID/EX loads a bubble. Normally asserted together with IFID_stall_i.
- EX/MEM otherwise loads every cycle.
- IF/ID valid is 1 on every non-flush load.

EX resolution (combinational):
- Condition by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 give not-taken.
- taken = is_jmp | (is_br & cond).
- target = is_jalr ? ((rs1+imm) & ~1) : (pc+imm). All adds are modulo 2^32.
- pcplus4 = pc+4, modulo 2^32.

Commit outputs (registered in EX/MEM):
- Let ctl = valid & (is_br | is_jmp).
- EXMEM_is_jmp_o = ctl.
- EXMEM_br_decision_o = ctl & taken.
- EXMEM_btb_hit_o = ctl & hit & (~taken | btb_target==target). A hit with a wrong target (JALR) is reported as a miss. The predictor then redirects to EXMEM_br_target_o with flush and rewrites the BTB entry.
- Non-control instructions and bubbles: is_jmp=0, decision=0, hit=0. The predictor therefore never flushes on them.
- Latency: 3 clock edges from IF capture to commit outputs, absent stalls.

Counters:
- Updated on each clock where EXMEM_is_jmp_o=1.
- br_count_o increments by 1 on each such clock.
- mispredict_count_o increments when EXMEM_btb_hit_o != EXMEM_br_decision_o.
- Both saturate at 32'hFFFF_FFFF; no wrap-around.

Reset (asynchronous, active-low):
- All valid bits and all outputs go to 0, including counters.
- Reset asserted mid-operation discards all in-flight entries immediately.
- First commit output is possible 3 edges after rst_ni deasserts.

Simultaneous events:
- flush_i with IFID_stall_i or IDEX_bubble_i: flush wins.
- Commit of a mispredicted branch coincides with its own flush: its counter update still happens, because the counter reads the current EX/MEM contents.

Decomposition:
- Shared package branch_pkg:
  - funct3 localparams (BEQ/BNE/BLT/BGE/BLTU/BGEU)
  - TAG_WIDTH derivation function
  - packed structs ifid_meta_t, idex_meta_t, exmem_meta_t
- One sub-module branch_comparator: combinational rs1/rs2/funct3 -> cond.

Test Plan:
- BEQ at pc 0x100, imm 0x40, rs1=rs2=5, IF_btb_hit_i=0 -> 3 edges later: decision=1, hit=0, br_target=0x140, index=0x100[7:2]=0x00, tag=0x100>>8=0x1, mispredict_count=1.
- BNE at 0x200 with hit=1, btb_target=0x180, rs1=rs2 -> decision=0, hit=1, pcplus4=0x204, mispredict_count increments by 1.
- JALR rs1=0x1001, imm=4, hit=1, btb_target=0x2000 -> target=0x1004, hit reported 0, decision=1, br_count increments by 1.
- flush_i pulsed while a branch is in ID and another is in EX -> next 2 commit cycles: is_jmp=0, decision=0, counters unchanged.
- IFID_stall_i+IDEX_bubble_i for 2 cycles with a BLTU (rs1=1, rs2=0xFFFFFFFF) in IF/ID -> IF/ID holds, bubbles committed, branch later commits with decision=1.
- Preload both counters to 0xFFFFFFFF via forced saturation, then commit a mispredict -> both remain 0xFFFFFFFF. Then assert rst_ni=0 mid-pipeline -> all outputs become 0 asynchronously.
